mu0_mem_responder: RTL and testbench
====================================

// Module: mu0_mem_responder
// PURPOSE
//  Memory-side responder for the MU0 12-bit address / 16-bit data bus.
//  Accepts single read/write requests from the CPU (initiator), inserts a
//  programmable number of wait states, then completes the access with a
//  one-cycle Ack and registered read data. Serves as the memory model behind
//  the datapath register file in system simulation and FPGA builds.
// PARAMETERS
//  DATA_W       16  data word width
//  ADDR_W       12  bus address width
//  DEPTH_LOG2    8  log2 of implemented words; address decode uses Addr[DEPTH_LOG2-1:0]
//  WAIT_STATES   2  extra cycles before completion (0..15)
// PORTS
//  Clk    in   1       rising-edge clock
//  Reset  in   1       asynchronous, active-low reset
//  Req    in   1       request valid; sampled only while idle
//  Wr     in   1       1 = write, 0 = read; sampled with Req
//  Addr   in   ADDR_W  word address; sampled with Req
//  WData  in   DATA_W  write data; sampled with Req
//  Ack    out  1       one-cycle completion pulse
//  RData  out  DATA_W  read data, valid while Ack=1
//  Busy   out  1       1 while a transaction is in progress
// BEHAVIOUR
//  - Reset (Reset=0, async): state=IDLE, Ack=0, RData=0, Busy=0, wait count=0.
//    Memory array is not reset; contents undefined until written.
//  - States: IDLE, WAIT, DONE. Busy = (state != IDLE), registered.
//  - IDLE: on edge with Req=1, capture Wr/Addr/WData into internal latches.
//    WAIT_STATES=0 -> perform access on this edge, go DONE.
//    else load count=WAIT_STATES, go WAIT.
//  - WAIT: count==1 -> perform access on this edge, go DONE; else count--.
//  - Access: write stores captured WData at captured address, RData<=WData
//    (write echo); read loads RData<=mem[addr]. Ack<=1 on same edge.
//  - DONE: next edge Ack<=0, go IDLE. RData holds its value until next access.
//  - Latency: Ack rises WAIT_STATES edges after the capture edge (same edge
//    when 0); high for exactly one cycle.
//  - Req/Wr/Addr/WData changes while Busy=1 are ignored; Req is not queued.
//  - Req high in IDLE directly after DONE starts a new transaction
//    (back-to-back); min spacing between Acks = WAIT_STATES+2 cycles.
//  - Address aliasing: bits above DEPTH_LOG2 ignored; 0x105 and 0x005 alias at 8.
//  - Reset mid-transaction (WAIT or DONE): abort immediately, no memory write
//    if asserted before the access edge, Ack never pulses for that request.
//  - Reset released coincident with Req=1: Req sampled on first edge after release.
// TESTING
//  1. Reset asserted, Clk running -> Ack=0, RData=0x0000, Busy=0 throughout.
//  2. WAIT_STATES=2: write 0x1234 @0x005, then read @0x005 -> Ack rises 2 edges
//     after capture, RData=0x1234, Busy high 3 cycles per access.
//  3. Req held high for 2 reads (@0x001=0xAAAA, @0x002=0x5555) -> two Ack pulses
//     4 cycles apart, RData 0xAAAA then 0x5555.
//  4. During WAIT, change Addr to 0x0FF and WData to 0xFFFF -> original access
//     completes unaffected; mem[0x0FF] unchanged.
//  5. DEPTH_LOG2=8: write 0xBEEF @0x105, read @0x005 -> RData=0xBEEF.
//  6. Reset pulsed in WAIT of write 0x9999 @0x010 (old 0x1111) -> no Ack;
//     subsequent read @0x010 returns 0x1111. Also WAIT_STATES=0: Ack on capture edge.

Source files
------------

// File: rtl/mu0_mem_responder.sv
// ---------------------------------------------------------------------------
// mu0_mem_responder
//   Memory-side responder for the MU0 bus (12-bit word address, 16-bit data).
//   Takes one read or write request at a time from the CPU. It waits a
//   programmable number of cycles, then completes the access with a one-cycle
//   Ack and registered read data.
//
//   Ports
//     Clk    in   1       rising-edge clock
//     Reset  in   1       asynchronous, active-low reset
//     Req    in   1       request valid, sampled only while idle
//     Wr     in   1       1 = write, 0 = read (sampled with Req)
//     Addr   in   ADDR_W  word address (sampled with Req)
//     WData  in   DATA_W  write data (sampled with Req)
//     Ack    out  1       one-cycle completion pulse
//     RData  out  DATA_W  read data, or echo of the write data; valid with Ack
//     Busy   out  1       high while a transaction is in flight (registered)
//
//   Parameters
//     DATA_W       data word width
//     ADDR_W       bus address width
//     DEPTH_LOG2   log2 of implemented words; upper address bits alias
//     WAIT_STATES  extra cycles between capture and completion (0..15)
// ---------------------------------------------------------------------------
module mu0_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Ack,
    output logic [DATA_W-1:0] RData,
    output logic              Busy
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [3:0]              count, count_d;

    // Request fields held for the whole transaction, so that bus changes
    // during Busy have no effect.
    logic                    wr_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DATA_W-1:0]       wdata_q;

    logic                    capture;
    logic                    access;
    logic                    acc_wr;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [DATA_W-1:0]       acc_wdata;

    logic [DATA_W-1:0]       mem [DEPTH];

    // Only the low DEPTH_LOG2 address bits are decoded. Higher bits alias.
    generate
        if (ADDR_W > DEPTH_LOG2) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^Addr[ADDR_W-1:DEPTH_LOG2];
        end
    endgenerate

    // ---------------------------------------------------------------- state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state;
        count_d = count;
        unique case (state)
            S_IDLE: begin
                if (Req) begin
                    if (WS == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        count_d = WS;
                    end
                end
            end
            S_WAIT: begin
                if (count == 4'd1) state_d = S_DONE;
                else               count_d = count - 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // --------------------------------------------------------- output decode
    // With zero wait states the access happens on the capture edge. In that
    // case the live bus fields are used, because the holding registers are
    // only being loaded on that same edge.
    always_comb begin
        capture   = (state == S_IDLE) && Req;
        access    = Reset && (((WS == 4'd0) && capture) ||
                              ((state == S_WAIT) && (count == 4'd1)));
        acc_wr    = capture ? Wr                      : wr_q;
        acc_idx   = capture ? Addr[DEPTH_LOG2-1:0]    : idx_q;
        acc_wdata = capture ? WData                   : wdata_q;
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Ack     <= 1'b0;
            Busy    <= 1'b0;
            RData   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            Ack  <= access;
            Busy <= (state_d != S_IDLE);
            if (capture) begin
                wr_q    <= Wr;
                idx_q   <= Addr[DEPTH_LOG2-1:0];
                wdata_q <= WData;
            end
            // A write echoes its data on RData. Otherwise RData holds its
            // value until the next access.
            if (access)
                RData <= acc_wr ? acc_wdata : mem[acc_idx];
        end
    end

    // The storage array has no reset. Its contents are undefined until
    // written. The access term is gated by Reset, so a reset that lands
    // before the access edge also cancels the write.
    always_ff @(posedge Clk) begin
        if (access && acc_wr)
            mem[acc_idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_mu0_mem_responder.sv
module tb_mu0_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    // WAIT_STATES=2 instance
    logic        req2, wr2, ack2, busy2;
    logic [11:0] addr2;
    logic [15:0] wdata2, rdata2;
    // WAIT_STATES=0 instance
    logic        req0, wr0, ack0, busy0;
    logic [11:0] addr0;
    logic [15:0] wdata0, rdata0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mu0_mem_responder #(.DATA_W(16), .ADDR_W(12), .DEPTH_LOG2(8), .WAIT_STATES(2)) u_ws2 (
        .Clk(clk), .Reset(rst_n), .Req(req2), .Wr(wr2), .Addr(addr2), .WData(wdata2),
        .Ack(ack2), .RData(rdata2), .Busy(busy2)
    );

    mu0_mem_responder #(.DATA_W(16), .ADDR_W(12), .DEPTH_LOG2(8), .WAIT_STATES(0)) u_ws0 (
        .Clk(clk), .Reset(rst_n), .Req(req0), .Wr(wr0), .Addr(addr0), .WData(wdata0),
        .Ack(ack0), .RData(rdata0), .Busy(busy0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one single-cycle-Req transaction on the WAIT_STATES=2 instance.
    // It returns the Ack edge index (0 = capture edge, -1 = never), the RData
    // seen with Ack, the number of cycles with Busy high and the number of
    // cycles with Ack high.
    task automatic xact2(input logic w, input logic [11:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd,
                         output int bc, output int ac);
        lat = -1; rd = 16'hxxxx; bc = 0; ac = 0;
        req2 = 1'b1; wr2 = w; addr2 = a; wdata2 = d;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) req2 = 1'b0;
            if (busy2) bc++;
            if (ack2) begin
                ac++;
                if (lat < 0) begin lat = i; rd = rdata2; end
            end
            if (!busy2) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req2 = 1'b1; wr2 = 1'b1; addr2 = 12'h005; wdata2 = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (ack2 !== 1'b0)       begin fails++; $display("FAIL reset_ack2 cyc%0d got %b want 0", i, ack2); end
            tests++; if (busy2 !== 1'b0)      begin fails++; $display("FAIL reset_busy2 cyc%0d got %b want 0", i, busy2); end
            tests++; if (rdata2 !== 16'h0000) begin fails++; $display("FAIL reset_rdata2 cyc%0d got %h want 0000", i, rdata2); end
            tests++; if (ack0 !== 1'b0 || busy0 !== 1'b0 || rdata0 !== 16'h0000)
                begin fails++; $display("FAIL reset_ws0 cyc%0d got ack=%b busy=%b rdata=%h want 0/0/0000", i, ack0, busy0, rdata0); end
        end
        req2 = 1'b0;
        rst_n = 1'b1;
        tick();
        tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL reset_req_ignored busy got %b want 0", busy2); end
    endtask

    task automatic test_write_read;
        int lat, bc, ac; logic [15:0] rd;
        xact2(1'b1, 12'h005, 16'h1234, lat, rd, bc, ac);
        tests++; if (lat !== 2)         begin fails++; $display("FAIL wr_latency got %0d want 2", lat); end
        tests++; if (rd !== 16'h1234)   begin fails++; $display("FAIL wr_echo got %h want 1234", rd); end
        tests++; if (bc !== 3)          begin fails++; $display("FAIL wr_busy_cycles got %0d want 3", bc); end
        tests++; if (ac !== 1)          begin fails++; $display("FAIL wr_ack_width got %0d want 1", ac); end
        xact2(1'b0, 12'h005, 16'h0000, lat, rd, bc, ac);
        tests++; if (lat !== 2)         begin fails++; $display("FAIL rd_latency got %0d want 2", lat); end
        tests++; if (rd !== 16'h1234)   begin fails++; $display("FAIL rd_data got %h want 1234", rd); end
        tests++; if (bc !== 3)          begin fails++; $display("FAIL rd_busy_cycles got %0d want 3", bc); end
        tests++; if (ac !== 1)          begin fails++; $display("FAIL rd_ack_width got %0d want 1", ac); end
        tick();
        tests++; if (rdata2 !== 16'h1234) begin fails++; $display("FAIL rdata_hold got %h want 1234", rdata2); end
    endtask

    task automatic test_back_to_back;
        int lat, bc, ac, n, t1, t2; logic [15:0] rd, r1, r2;
        xact2(1'b1, 12'h001, 16'hAAAA, lat, rd, bc, ac);
        xact2(1'b1, 12'h002, 16'h5555, lat, rd, bc, ac);
        n = 0; t1 = -1; t2 = -1; r1 = 16'hxxxx; r2 = 16'hxxxx;
        req2 = 1'b1; wr2 = 1'b0; addr2 = 12'h001;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack2) begin
                n++;
                if (n == 1) begin t1 = i; r1 = rdata2; addr2 = 12'h002; end
                else begin t2 = i; r2 = rdata2; req2 = 1'b0; break; end
            end
        end
        req2 = 1'b0;
        tick();
        tests++; if (n !== 2)             begin fails++; $display("FAIL b2b_ack_count got %0d want 2", n); end
        tests++; if (t1 !== 2)            begin fails++; $display("FAIL b2b_first_latency got %0d want 2", t1); end
        tests++; if (t2 - t1 !== 4)       begin fails++; $display("FAIL b2b_spacing got %0d want 4", t2 - t1); end
        tests++; if (r1 !== 16'hAAAA)     begin fails++; $display("FAIL b2b_rdata1 got %h want AAAA", r1); end
        tests++; if (r2 !== 16'h5555)     begin fails++; $display("FAIL b2b_rdata2 got %h want 5555", r2); end
    endtask

    task automatic test_bus_change_ignored;
        int lat, bc, ac; logic [15:0] rd, echo;
        xact2(1'b1, 12'h0FF, 16'h0F0F, lat, rd, bc, ac);
        lat = -1; echo = 16'hxxxx;
        req2 = 1'b1; wr2 = 1'b1; addr2 = 12'h020; wdata2 = 16'h4321;
        tick();
        req2 = 1'b0; addr2 = 12'h0FF; wdata2 = 16'hFFFF;
        for (int i = 1; i < 20; i++) begin
            tick();
            if (ack2) begin lat = i; echo = rdata2; break; end
        end
        tick();
        tests++; if (lat !== 2)           begin fails++; $display("FAIL chg_latency got %0d want 2", lat); end
        tests++; if (echo !== 16'h4321)   begin fails++; $display("FAIL chg_echo got %h want 4321", echo); end
        xact2(1'b0, 12'h0FF, 16'h0000, lat, rd, bc, ac);
        tests++; if (rd !== 16'h0F0F)     begin fails++; $display("FAIL chg_mem0FF got %h want 0F0F", rd); end
        xact2(1'b0, 12'h020, 16'h0000, lat, rd, bc, ac);
        tests++; if (rd !== 16'h4321)     begin fails++; $display("FAIL chg_mem020 got %h want 4321", rd); end
    endtask

    task automatic test_alias;
        int lat, bc, ac; logic [15:0] rd;
        xact2(1'b1, 12'h105, 16'hBEEF, lat, rd, bc, ac);
        xact2(1'b0, 12'h005, 16'h0000, lat, rd, bc, ac);
        tests++; if (rd !== 16'hBEEF) begin fails++; $display("FAIL alias_005 got %h want BEEF", rd); end
        xact2(1'b0, 12'hF05, 16'h0000, lat, rd, bc, ac);
        tests++; if (rd !== 16'hBEEF) begin fails++; $display("FAIL alias_F05 got %h want BEEF", rd); end
    endtask

    task automatic test_reset_abort;
        int lat, bc, ac, acks; logic [15:0] rd;
        acks = 0;
        xact2(1'b1, 12'h010, 16'h1111, lat, rd, bc, ac);
        req2 = 1'b1; wr2 = 1'b1; addr2 = 12'h010; wdata2 = 16'h9999;
        tick();                       // capture
        req2 = 1'b0;
        tick();                       // still waiting
        rst_n = 1'b0;
        #1;
        tests++; if (busy2 !== 1'b0 || ack2 !== 1'b0 || rdata2 !== 16'h0000)
            begin fails++; $display("FAIL abort_async got busy=%b ack=%b rdata=%h want 0/0/0000", busy2, ack2, rdata2); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack2) acks++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack2) acks++;
        end
        tests++; if (acks !== 0) begin fails++; $display("FAIL abort_no_ack got %0d acks want 0", acks); end
        xact2(1'b0, 12'h010, 16'h0000, lat, rd, bc, ac);
        tests++; if (rd !== 16'h1111) begin fails++; $display("FAIL abort_mem got %h want 1111", rd); end
        tests++; if (lat !== 2)       begin fails++; $display("FAIL abort_recover_latency got %0d want 2", lat); end
    endtask

    task automatic test_zero_wait;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 12'h033; wdata0 = 16'h7777;
        tick();
        tests++; if (ack0 !== 1'b1 || rdata0 !== 16'h7777 || busy0 !== 1'b1)
            begin fails++; $display("FAIL ws0_write got ack=%b rdata=%h busy=%b want 1/7777/1", ack0, rdata0, busy0); end
        req0 = 1'b0;
        tick();
        tests++; if (ack0 !== 1'b0 || busy0 !== 1'b0)
            begin fails++; $display("FAIL ws0_done got ack=%b busy=%b want 0/0", ack0, busy0); end
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h133; wdata0 = 16'h0000;
        tick();
        tests++; if (ack0 !== 1'b1 || rdata0 !== 16'h7777)
            begin fails++; $display("FAIL ws0_read got ack=%b rdata=%h want 1/7777", ack0, rdata0); end
        req0 = 1'b0;
        tick();
        // Req held through reset: ignored until release, then sampled on the
        // first edge after release.
        rst_n = 1'b0;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h033;
        tick();
        tick();
        tests++; if (ack0 !== 1'b0 || busy0 !== 1'b0)
            begin fails++; $display("FAIL ws0_in_reset got ack=%b busy=%b want 0/0", ack0, busy0); end
        rst_n = 1'b1;
        tick();
        tests++; if (ack0 !== 1'b1 || rdata0 !== 16'h7777)
            begin fails++; $display("FAIL ws0_release_req got ack=%b rdata=%h want 1/7777", ack0, rdata0); end
        req0 = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_bus_change_ignored();
        test_alias();
        test_reset_abort();
        test_zero_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
